// File: rtl/instr_fetch_buffer.sv
// Instruction store and sequencer: captures DMA instruction writes, then streams
// them in address order over valid/ready until a HALT opcode or program end.
module instr_fetch_buffer #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned INSTR_W     = 32,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_wr_en_i,
  input  logic [ADDR_W-1:0]   instr_wr_addr_i,
  input  logic [INSTR_W-1:0]  instr_wr_data_i,
  input  logic                clear_prog_i,
  input  logic                start_execution_i,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  output logic [INSTR_W-1:0]  instr_data_o,
  output logic [ADDR_W-1:0]   instr_pc_o,
  output logic                exec_busy_o,
  output logic                exec_done_o,
  output logic                wr_reject_o,
  output logic [ADDR_W:0]     prog_len_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e               state_q;
  logic [INSTR_W-1:0]   mem [DEPTH];
  logic [ADDR_W:0]      pc_q;
  logic [ADDR_W:0]      prog_len_q;
  logic [ADDR_W:0]      prog_len_d;
  logic [ADDR_W:0]      wr_len;
  logic [ADDR_W:0]      len_base;
  logic [INSTR_W-1:0]   data_q;
  logic [INSTR_W-1:0]   rd_word;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 reject_q;
  logic                 wr_ok;

  assign wr_ok = (state_q == S_IDLE) || (state_q == S_DONE);

  // Clear applies before a same-cycle write, so the write defines the new length.
  always_comb begin
    len_base   = clear_prog_i ? '0 : prog_len_q;
    wr_len     = {1'b0, instr_wr_addr_i} + (ADDR_W+1)'(1);
    prog_len_d = prog_len_q;
    if (wr_ok) begin
      if (instr_wr_en_i) begin
        prog_len_d = (wr_len > len_base) ? wr_len : len_base;
      end else if (clear_prog_i) begin
        prog_len_d = '0;
      end
    end
  end

  assign rd_word = mem[pc_q[ADDR_W-1:0]];

  // Instruction RAM; contents survive reset, only prog_len marks validity.
  always_ff @(posedge clk) begin
    if (rst_n && instr_wr_en_i && wr_ok) begin
      mem[instr_wr_addr_i] <= instr_wr_data_i;
    end
  end

  // pc is one bit wider than the RAM address so pc == prog_len == DEPTH ends the run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      prog_len_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      reject_q   <= instr_wr_en_i && !wr_ok;
      prog_len_q <= prog_len_d;
      case (state_q)
        S_IDLE: begin
          if (start_execution_i) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (pc_q == prog_len_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            data_q  <= rd_word;
            valid_q <= (rd_word[INSTR_W-1 -: 8] != HALT_OPCODE);
            state_q <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (data_q[INSTR_W-1 -: 8] == HALT_OPCODE) begin
            state_q <= S_DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (valid_q && instr_ready_i) begin
            valid_q <= 1'b0;
            pc_q    <= pc_q + (ADDR_W+1)'(1);
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_data_o  = data_q;
  assign instr_pc_o    = pc_q[ADDR_W-1:0];
  assign exec_busy_o   = busy_q;
  assign exec_done_o   = done_q;
  assign wr_reject_o   = reject_q;
  assign prog_len_o    = prog_len_q;

endmodule
